// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared widths, debug FSM states and write-queue entry type for the reg_bank arbiter.
package reg_bank_pkg;
  localparam int DIR = 5;
  localparam int BUS = 2 ** DIR;
  localparam int WAIT_MAX = 8;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ACK} dbg_state_t;
  typedef struct packed {
    logic [DIR-1:0] addr;
    logic [BUS-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: writeback, multi-cycle, decode, debug and bank-port signals of the arbiter.
interface reg_bank_arbiter_if import reg_bank_pkg::*; #(
  parameter int dir = DIR,
  parameter int bus = BUS
);
  logic           wb_we;
  logic [dir-1:0] wb_addr;
  logic [bus-1:0] wb_data;
  logic           mc_valid;
  logic [dir-1:0] mc_addr;
  logic [bus-1:0] mc_data;
  logic           mc_ready;
  logic           id_rd_en;
  logic [dir-1:0] id_ra;
  logic [dir-1:0] id_rb;
  logic           dbg_req;
  logic           dbg_we;
  logic [dir-1:0] dbg_addr;
  logic [bus-1:0] dbg_wdata;
  logic           dbg_ack;
  logic [bus-1:0] dbg_rdata;
  logic [dir-1:0] da;
  logic [dir-1:0] db;
  logic           memread;
  logic [dir-1:0] addr_write;
  logic [bus-1:0] write_data;
  logic           memwrite;
  logic [bus-1:0] doa;
  logic           stall;
  modport slave (
    input  wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, id_rd_en, id_ra, id_rb,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, doa,
    output mc_ready, dbg_ack, dbg_rdata, da, db, memread, addr_write, write_data, memwrite, stall
  );
  modport master (
    output wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, id_rd_en, id_ra, id_rb,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, doa,
    input  mc_ready, dbg_ack, dbg_rdata, da, db, memread, addr_write, write_data, memwrite, stall
  );
endinterface

// File: rtl/reg_bank_wq.sv
// reg_bank_wq: 2-entry shift FIFO of late results; slot 0 is always the head.
module reg_bank_wq import reg_bank_pkg::*; #(
  parameter type entry_t = wq_entry_t,
  parameter int  aw      = DIR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  entry_t              din,
  output logic                full,
  output logic                empty,
  output entry_t              head,
  output logic [1:0]          vld,
  output logic [1:0][aw-1:0]  addrs
);
  entry_t [1:0] ent;
  logic   [1:0] cnt;
  // push is only offered when not full, so push with pop implies exactly one entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      if (pop) ent[0] <= push ? din : ent[1];
      else if (push) ent[cnt[0]] <= din;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign head  = ent[0];
  assign vld   = {full, !empty};
  assign addrs = {ent[1].addr, ent[0].addr};
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares the reg_bank write port between writeback, queued late results and debug,
// and raises stall on queued-result hazards and while debug borrows the read port.
module reg_bank_arbiter import reg_bank_pkg::*; #(
  parameter int dir      = DIR,
  parameter int bus      = BUS,
  parameter int wait_max = WAIT_MAX
) (
  input logic               clk,
  input logic               rst_n,
  reg_bank_arbiter_if.slave io
);
  typedef struct packed {
    logic [dir-1:0] addr;
    logic [bus-1:0] data;
  } entry_t;
  localparam int cw = $clog2(wait_max + 1);
  dbg_state_t          state, state_n;
  logic [cw-1:0]       wait_cnt;
  logic [bus-1:0]      rdata;
  logic                full, empty, push, pop, grant, dbg_wr, hit_a, hit_b;
  logic [1:0]          vld;
  logic [1:0][dir-1:0] q_addr;
  entry_t              head, win;
  reg_bank_wq #(.entry_t(entry_t), .aw(dir)) wq (
    .clk, .rst_n, .push, .pop,
    .din({io.mc_addr, io.mc_data}),
    .full, .empty, .head, .vld,
    .addrs(q_addr)
  );
  always_comb begin
    push   = io.mc_valid && !full;
    pop    = !io.wb_we && !empty;
    grant  = !io.wb_we && empty;
    dbg_wr = state == WR && grant;
    win    = io.wb_we ? entry_t'({io.wb_addr, io.wb_data}) :
             !empty   ? head :
             dbg_wr   ? entry_t'({io.dbg_addr, io.dbg_wdata}) : '0;
    hit_a  = io.id_ra != '0 && ((vld[0] && q_addr[0] == io.id_ra) || (vld[1] && q_addr[1] == io.id_ra));
    hit_b  = io.id_rb != '0 && ((vld[0] && q_addr[0] == io.id_rb) || (vld[1] && q_addr[1] == io.id_rb));
    state_n = state;
    case (state)
      IDLE:    state_n = io.dbg_req ? (io.dbg_we ? WR : RD) : IDLE;
      RD:      state_n = CAP;
      CAP:     state_n = ACK;
      WR:      state_n = grant ? ACK : WR;
      ACK:     state_n = io.dbg_req ? ACK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= state == IDLE ? '0 :
                  state == WR && !grant && wait_cnt != cw'(wait_max) ? wait_cnt + cw'(1) : wait_cnt;
      if (state == CAP) rdata <= io.doa;
    end
  // the idle winner is all-zero, so a nonzero address means a real, non-$0 write
  assign io.memwrite   = |win.addr;
  assign io.addr_write = win.addr;
  assign io.write_data = win.data;
  assign io.mc_ready   = !full;
  assign io.da         = state == RD ? io.dbg_addr : io.id_ra;
  assign io.db         = io.id_rb;
  assign io.memread    = state == RD || io.id_rd_en;
  assign io.dbg_ack    = state == ACK;
  assign io.dbg_rdata  = rdata;
  assign io.stall      = (io.id_rd_en && (hit_a || hit_b)) || state == RD ||
                         (state == WR && !grant && wait_cnt == cw'(wait_max));
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: table-driven write/queue/hazard vectors plus hand sequences for debug and reset.
module tb_reg_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reg_bank_arbiter_if #(.dir(5), .bus(32)) io();
  reg_bank_arbiter dut (.clk(clk), .rst_n(rst_n), .io(io));
  logic [31:0] mem [32] = '{default: '0};
  always @(negedge clk) if (io.memwrite) mem[io.addr_write] <= io.write_data;
  always @(posedge clk) if (io.memread) io.doa <= mem[io.da];
  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        rd;
    logic [4:0]  ra, rb;
    logic        e_mw;
    logic [4:0]  e_aw;
    logic [31:0] e_wd;
    logic        e_rdy, e_stall;
  } vec_t;
  vec_t vt[$];
  int n_vec = 0;
  int n_bad = 0;
  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic mv, logic [4:0] ma,
                              logic [31:0] md, logic rd, logic [4:0] ra, logic [4:0] rb, logic e_mw,
                              logic [4:0] e_aw, logic [31:0] e_wd, logic e_rdy, logic e_stall);
    mk = '{we, wa, wd, mv, ma, md, rd, ra, rb, e_mw, e_aw, e_wd, e_rdy, e_stall};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic idle_in();
    io.wb_we = 0; io.wb_addr = 0; io.wb_data = 0;
    io.mc_valid = 0; io.mc_addr = 0; io.mc_data = 0;
    io.id_rd_en = 0; io.id_ra = 0; io.id_rb = 0;
    io.dbg_req = 0; io.dbg_we = 0; io.dbg_addr = 0; io.dbg_wdata = 0;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_ack"}, io.dbg_ack, 0);
    chk({tag, "_rdy"}, io.mc_ready, 1);
    chk({tag, "_stall"}, io.stall, 0);
    chk({tag, "_mw"}, io.memwrite, 0);
    chk({tag, "_mr"}, io.memread, 0);
    chk({tag, "_da"}, io.da, 0);
    chk({tag, "_db"}, io.db, 0);
    chk({tag, "_aw"}, io.addr_write, 0);
    chk({tag, "_wd"}, io.write_data, 0);
    chk({tag, "_rdata"}, io.dbg_rdata, 0);
  endtask
  initial begin
    //            we wa  wd           mv ma  md          rd ra  rb   mw aw  wd           rdy st
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    0, 0, 0,           1, 0));
    vt.push_back(mk(1, 3, 32'h11,      1, 5, 32'hAA,     0, 0, 0,    1, 3, 32'h11,      1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    1, 5, 32'hAA,      1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    0, 0, 0,           1, 0));
    vt.push_back(mk(1, 1, 32'h100,     1, 6, 32'h66,     0, 0, 0,    1, 1, 32'h100,     1, 0));
    vt.push_back(mk(1, 2, 32'h200,     1, 7, 32'h77,     0, 0, 0,    1, 2, 32'h200,     1, 0));
    vt.push_back(mk(1, 4, 32'h400,     0, 0, 0,          0, 0, 0,    1, 4, 32'h400,     0, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    1, 6, 32'h66,      0, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    1, 7, 32'h77,      1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    0, 0, 0,           1, 0));
    vt.push_back(mk(1, 8, 32'h80,      1, 7, 32'h70,     1, 7, 0,    1, 8, 32'h80,      1, 0));
    vt.push_back(mk(1, 8, 32'h81,      0, 0, 0,          1, 7, 0,    1, 8, 32'h81,      1, 1));
    vt.push_back(mk(1, 10, 32'hA0,     0, 0, 0,          1, 0, 7,    1, 10, 32'hA0,     1, 1));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          1, 7, 0,    1, 7, 32'h70,      1, 1));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          1, 7, 0,    0, 0, 0,           1, 0));
    vt.push_back(mk(1, 3, 32'h33,      1, 0, 32'h5,      0, 0, 0,    1, 3, 32'h33,      1, 0));
    vt.push_back(mk(1, 2, 32'h22,      0, 0, 0,          1, 0, 0,    1, 2, 32'h22,      1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          1, 0, 0,    0, 0, 32'h5,       1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    0, 0, 0,           1, 0));
    vt.push_back(mk(1, 0, 32'h99,      0, 0, 0,          0, 0, 0,    0, 0, 32'h99,      1, 0));
    vt.push_back(mk(1, 9, 32'hDEADBEEF, 0, 0, 0,         0, 0, 0,    1, 9, 32'hDEADBEEF, 1, 0));
    vt.push_back(mk(0, 0, 0,           0, 0, 0,          0, 0, 0,    0, 0, 0,           1, 0));
    idle_in();
    #2 chk_reset("reset");
    @(posedge clk); #1 rst_n = 1;
    foreach (vt[i]) begin
      @(posedge clk); #1
      io.wb_we = vt[i].wb_we; io.wb_addr = vt[i].wb_addr; io.wb_data = vt[i].wb_data;
      io.mc_valid = vt[i].mc_valid; io.mc_addr = vt[i].mc_addr; io.mc_data = vt[i].mc_data;
      io.id_rd_en = vt[i].rd; io.id_ra = vt[i].ra; io.id_rb = vt[i].rb;
      #2
      chk($sformatf("v%0d_memwrite", i), io.memwrite, vt[i].e_mw);
      chk($sformatf("v%0d_addr_write", i), io.addr_write, vt[i].e_aw);
      chk($sformatf("v%0d_write_data", i), io.write_data, vt[i].e_wd);
      chk($sformatf("v%0d_mc_ready", i), io.mc_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_stall", i), io.stall, vt[i].e_stall);
      chk($sformatf("v%0d_da", i), io.da, vt[i].ra);
      chk($sformatf("v%0d_memread", i), io.memread, vt[i].rd);
    end
    chk("mem0_protected", mem[0], 0);
    // debug read of addr 9
    @(posedge clk); #1 idle_in(); io.dbg_req = 1; io.dbg_addr = 9;
    #2 chk("dr_idle_stall", io.stall, 0);
    @(posedge clk); #3
    chk("dr_rd_stall", io.stall, 1); chk("dr_rd_da", io.da, 9);
    chk("dr_rd_memread", io.memread, 1); chk("dr_rd_ack", io.dbg_ack, 0);
    @(posedge clk); #3
    chk("dr_cap_stall", io.stall, 0); chk("dr_cap_ack", io.dbg_ack, 0);
    @(posedge clk); #3
    chk("dr_ack", io.dbg_ack, 1); chk("dr_rdata", io.dbg_rdata, 32'hDEADBEEF);
    @(posedge clk); #3 chk("dr_ack_held", io.dbg_ack, 1);
    @(posedge clk); #1 io.dbg_req = 0;
    #2 chk("dr_ack_drop_cycle", io.dbg_ack, 1);
    @(posedge clk); #3 chk("dr_ack_clear", io.dbg_ack, 0);
    // debug write starved by continuous writeback
    @(posedge clk); #1
    io.wb_we = 1; io.wb_addr = 1; io.wb_data = 32'h1111;
    io.dbg_req = 1; io.dbg_we = 1; io.dbg_addr = 12; io.dbg_wdata = 32'hC0FFEE;
    #2 chk("dw_idle_stall", io.stall, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #3 chk($sformatf("dw_wait%0d_stall", i), io.stall, 0);
    end
    @(posedge clk); #3
    chk("dw_timeout_stall", io.stall, 1); chk("dw_timeout_aw", io.addr_write, 1);
    @(posedge clk); #1 io.wb_we = 0;
    #2
    chk("dw_grant_mw", io.memwrite, 1); chk("dw_grant_aw", io.addr_write, 12);
    chk("dw_grant_wd", io.write_data, 32'hC0FFEE); chk("dw_grant_ack", io.dbg_ack, 0);
    @(posedge clk); #3
    chk("dw_ack", io.dbg_ack, 1); chk("dw_ack_stall", io.stall, 0);
    chk("dw_mem12", mem[12], 32'hC0FFEE);
    @(posedge clk); #1 io.dbg_req = 0;
    @(posedge clk); #3 chk("dw_ack_clear", io.dbg_ack, 0);
    // debug write to $0 is suppressed but still acked
    @(posedge clk); #1 io.dbg_req = 1; io.dbg_we = 1; io.dbg_addr = 0; io.dbg_wdata = 32'h5A;
    @(posedge clk); #3
    chk("dz_mw", io.memwrite, 0); chk("dz_aw", io.addr_write, 0); chk("dz_wd", io.write_data, 32'h5A);
    @(posedge clk); #3 chk("dz_ack", io.dbg_ack, 1);
    @(posedge clk); #1 io.dbg_req = 0;
    @(posedge clk); #3 chk("dz_ack_clear", io.dbg_ack, 0); chk("dz_mem0", mem[0], 0);
    // reset during CAP with a queued result pending
    @(posedge clk); #1
    io.dbg_req = 1; io.dbg_we = 0; io.dbg_addr = 9;
    io.wb_we = 1; io.wb_addr = 1; io.wb_data = 32'h2;
    io.mc_valid = 1; io.mc_addr = 13; io.mc_data = 32'hD;
    @(posedge clk); #1 io.mc_valid = 0; io.mc_addr = 0; io.mc_data = 0;
    #2 chk("rs_rd_stall", io.stall, 1); chk("rs_rd_rdy", io.mc_ready, 1);
    @(posedge clk); #1 idle_in(); rst_n = 0;
    #2 chk_reset("rs_async");
    @(posedge clk); #3 chk_reset("rs_hold");
    @(posedge clk); #1 rst_n = 1;
    #2 chk_reset("rs_release");
    @(posedge clk); #3
    chk("rs_post_ack", io.dbg_ack, 0); chk("rs_post_mw", io.memwrite, 0);
    chk("rs_post_rdata", io.dbg_rdata, 0); chk("rs_mem13", mem[13], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Sequencing and sharing controller for the `reg_bank` register file. It owns the bank's single write port and its read-enable/address lines. It arbitrates between three sources:
- the pipeline writeback stage;
- a 2-entry queue of late results from the multi-cycle unit (mult/div);
- a debug req/ack port.

It also raises `stall` on read hazards against queued results and while the debug port borrows the read port.

## Interface
- `dir`, 5, register address width
- `bus`, 2**`dir` (32), data width
- `WAIT_MAX`, 8, cycles a pending debug write waits before forcing `stall`

- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_we`, `wb_addr`, `wb_data`  in  1/`dir`/`bus`  writeback write, always accepted
- `mc_valid`, `mc_addr`, `mc_data`  in  1/`dir`/`bus`  multi-cycle result push
- `mc_ready`  out  1  queue not full
- `id_rd_en`, `id_ra`, `id_rb`  in  1/`dir`/`dir`  decode read request
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/`dir`/`bus`  debug request, held until ack
- `dbg_ack`  out  1  debug transaction complete
- `dbg_rdata`  out  `bus`  debug read data, valid while `dbg_ack`
- `da`, `db`, `memread`  out  `dir`/`dir`/1  to bank read port
- `addr_write`, `write_data`, `memwrite`  out  `dir`/`bus`/1  to bank write port
- `doa`  in  `bus`  bank read data A
- `stall`  out  1  hold decode/fetch

## Operation
- **Write priority, each cycle:** `wb_we` first, then the queue head, then a debug write. Bank outputs are combinational from the winner. The bank commits on the following negedge.
- **`$0` protection:** any winning write to address 0 drives `memwrite`=0. The source is still treated as served: the queue pops, and a debug write acks.
- **Queue:** 2-entry FIFO of {addr, data}.
  - `mc_ready` = !full. A push occurs on `mc_valid`&`mc_ready`.
  - A pop occurs when the head wins arbitration.
  - Push and pop in the same cycle leaves the count unchanged.
- **Read path:** by default `da`=`id_ra`, `db`=`id_rb`, `memread`=`id_rd_en`.
- **Hazard:** `stall`=1 when `id_rd_en` and either nonzero read address matches any valid queue entry's address.
  - A same-cycle `wb_addr` match is not a hazard, because the negedge write precedes the posedge read.
- **Debug FSM** (states in package enum):
  - IDLE: on `dbg_req`, go to RD if !`dbg_we`, otherwise go to WR.
  - RD (1 cycle): `da`=`dbg_addr`, `memread`=1, `stall`=1. Go to CAP.
  - CAP (1 cycle): capture `doa` into `dbg_rdata` at the closing posedge. Go to ACK.
  - WR: wait for a write grant (no `wb_we`, queue empty); on the grant cycle, drive the write. Go to ACK.
    - A wait counter increments per WR cycle without a grant. Once it reaches `WAIT_MAX`, `stall`=1 until the grant; the pipeline guarantees `wb_we` drains.
  - ACK: `dbg_ack`=1 until `dbg_req`=0, then go to IDLE. The counter clears in IDLE.
- `stall` = hazard | RD state | WR-timeout.

## Timing
- **Reset** (async assert, sync deassert handled upstream):
  - FSM=IDLE; queue empty; counter 0; `dbg_rdata`=0.
  - `dbg_ack`=0, `mc_ready`=1, `stall`=0, `memwrite`=0, `memread`=0, `da`=`db`=`addr_write`=0, `write_data`=0.
- **Reset mid-transaction:** the debug transaction is aborted with no ack, and queued results are discarded.
- **Latencies:**
  - A writeback write lands at the negedge of its cycle.
  - A queued result lands at the earliest cycle with no `wb_we`; the minimum is the cycle after the push.
  - A debug read asserts `dbg_ack` 2 cycles after leaving IDLE (RD, CAP, then ACK).
  - A debug write asserts `dbg_ack` the cycle after its grant.
- `dbg_req` dropping before ack is illegal. `dbg_addr`/`dbg_wdata` are sampled while the FSM is in RD/WR.
- A `dbg_req` held after ack does not start a new transaction until it has been deasserted for one cycle.

## Structure
- **Package `reg_bank_pkg`:** debug FSM state enum (IDLE, RD, CAP, WR, ACK), default `dir`/`bus`, `WAIT_MAX`, queue entry struct {addr, data}.
- **Sub-module `reg_bank_wq`:** parameterised 2-entry FIFO with full/empty and per-entry address outputs for hazard compare. All arbitration and FSM logic stays in the top.

## Test plan
- **Writeback beats queue:** push mc (addr 5, 0xAA) in the same cycle as `wb_we` (addr 3, 0x11). Required: addr 3 is written that cycle and addr 5 the next cycle; `mc_ready` stays 1.
- **Queue full:** push 2 mc entries while `wb_we` is held high. Required: `mc_ready`=0. Drop `wb_we`. Required: entries write in order on consecutive cycles and `mc_ready` returns to 1.
- **Hazard:** queue holds addr 7, decode reads `id_ra`=7. Required: `stall`=1 until the pop cycle and 0 after. A queued addr 0 with `id_ra`=0 gives no stall.
- **Debug read:** bank[9]=0xDEADBEEF, `dbg_req` read addr 9. Required: `stall` for 1 cycle (RD), then `dbg_ack`=1 with `dbg_rdata`=0xDEADBEEF 2 cycles after IDLE exit.
- **Debug write starvation:** `wb_we` held continuously. Required: `stall`=1 after 8 WR cycles. Release `wb_we`. Required: write lands, then `dbg_ack`.
- **Reset and `$0`:** assert `rst_n`=0 during CAP. Required: all outputs go to their reset values and no ack is issued. A write to addr 0 from any source produces `memwrite`=0.
